// File: rtl/z16_mem_arbiter_if.sv
// Bus bundle joining the instruction and data requesters, the arbiter and the memory.
// The slave modport is the arbiter's view. The master modport is the environment's view.
interface z16_mem_arbiter_if;
    logic        i_i_req;
    logic [15:0] i_i_addr;
    logic        o_i_gnt;
    logic        o_i_rvalid;
    logic [15:0] o_i_rdata;

    logic        i_d_req;
    logic        i_d_wen;
    logic        i_d_lock;
    logic [15:0] i_d_addr;
    logic [15:0] i_d_wdata;
    logic        o_d_gnt;
    logic        o_d_rvalid;
    logic [15:0] o_d_rdata;

    logic        o_mem_en;
    logic        o_mem_wen;
    logic [15:0] o_mem_addr;
    logic [15:0] o_mem_wdata;
    logic [15:0] i_mem_rdata;

    modport slave (
        input  i_i_req, i_i_addr, i_d_req, i_d_wen, i_d_lock, i_d_addr, i_d_wdata, i_mem_rdata,
        output o_i_gnt, o_i_rvalid, o_i_rdata, o_d_gnt, o_d_rvalid, o_d_rdata,
        output o_mem_en, o_mem_wen, o_mem_addr, o_mem_wdata
    );

    modport master (
        output i_i_req, i_i_addr, i_d_req, i_d_wen, i_d_lock, i_d_addr, i_d_wdata, i_mem_rdata,
        input  o_i_gnt, o_i_rvalid, o_i_rdata, o_d_gnt, o_d_rvalid, o_d_rdata,
        input  o_mem_en, o_mem_wen, o_mem_addr, o_mem_wdata
    );
endinterface

// File: rtl/z16_mem_arbiter.sv
// Instruction/data memory arbiter. It has a starvation guard for the instruction port and a bus lock for the data port.
// state | meaning
// ARB   | normal arbitration: D preferred unless I has waited MAX_WAIT cycles
// LOCK  | data port owns the bus; only D may be granted
module z16_mem_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    z16_mem_arbiter_if.slave      bus
);

    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_starve_cnt;
    logic        w_i_gnt;
    logic        w_d_gnt;

    logic        r_mem_en;
    logic        r_mem_wen;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_wdata;
    logic        r_s1_port;
    logic        r_s1_rd;
    logic        r_s2_valid;
    logic        r_s2_port;
    logic        w_i_rvalid;
    logic        w_d_rvalid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_i_gnt     = 1'b0;
        w_d_gnt     = 1'b0;
        case (r_state)
            ST_ARB: begin
                if (r_starve_cnt >= LP_MAX_WAIT && bus.i_i_req) begin
                    w_i_gnt = 1'b1;
                end else if (bus.i_d_req) begin
                    w_d_gnt = 1'b1;
                end else if (bus.i_i_req) begin
                    w_i_gnt = 1'b1;
                end
                if (w_d_gnt && bus.i_d_lock) begin
                    w_state_nxt = ST_LOCK;
                end
            end
            ST_LOCK: begin
                w_d_gnt = bus.i_d_req;
                if (!bus.i_d_lock) begin
                    w_state_nxt = ST_ARB;
                end
            end
            default: w_state_nxt = ST_ARB;
        endcase
    end

    // The wait counter keeps running while the bus is locked.
    // This lets I win the first ARB cycle after the lock is released.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve_cnt <= 4'd0;
        end else if (w_i_gnt) begin
            r_starve_cnt <= 4'd0;
        end else if (bus.i_i_req && r_starve_cnt != 4'hF) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    // Stage 1 is the memory command together with its owner tag.
    // Stage 2 marks the cycle in which read data returns.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem_en    <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_mem_addr  <= 16'h0000;
            r_mem_wdata <= 16'h0000;
            r_s1_port   <= 1'b0;
            r_s1_rd     <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s2_port   <= 1'b0;
        end else begin
            r_mem_en    <= w_i_gnt | w_d_gnt;
            r_mem_wen   <= w_d_gnt & bus.i_d_wen;
            r_mem_addr  <= w_d_gnt ? bus.i_d_addr : (w_i_gnt ? bus.i_i_addr : 16'h0000);
            r_mem_wdata <= w_d_gnt ? bus.i_d_wdata : 16'h0000;
            r_s1_port   <= w_d_gnt;
            r_s1_rd     <= ~(w_d_gnt & bus.i_d_wen);
            r_s2_valid  <= r_mem_en & r_s1_rd;
            r_s2_port   <= r_s1_port;
        end
    end

    assign w_i_rvalid      = r_s2_valid & ~r_s2_port;
    assign w_d_rvalid      = r_s2_valid & r_s2_port;

    assign bus.o_i_gnt     = w_i_gnt & i_rst_n;
    assign bus.o_d_gnt     = w_d_gnt & i_rst_n;
    assign bus.o_i_rvalid  = w_i_rvalid;
    assign bus.o_d_rvalid  = w_d_rvalid;
    assign bus.o_i_rdata   = w_i_rvalid ? bus.i_mem_rdata : 16'h0000;
    assign bus.o_d_rdata   = w_d_rvalid ? bus.i_mem_rdata : 16'h0000;
    assign bus.o_mem_en    = r_mem_en;
    assign bus.o_mem_wen   = r_mem_wen;
    assign bus.o_mem_addr  = r_mem_addr;
    assign bus.o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_z16_mem_arbiter.sv
// Testbench for z16_mem_arbiter. Each test checks grants where they happen.
// Expected memory commands and read returns go into queues, and a monitor pops and compares them every cycle.
module tb_z16_mem_arbiter;
    localparam int MAX_WAIT = 4;

    logic i_clk;
    logic i_rst_n;
    int   cyc = 0;
    bit   mon_en = 0;
    int   n_checks = 0;
    int   n_fails = 0;

    typedef struct {int cyc; logic wen; logic [15:0] addr; logic [15:0] wdata;} cmd_t;
    typedef struct {int cyc; logic port; logic [15:0] data;} rv_t;
    cmd_t cmd_q[$];
    rv_t  rv_q[$];

    z16_mem_arbiter_if bus();

    z16_mem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return a ^ 16'hBEFF;
    endfunction

    // The memory returns data one cycle after a read command.
    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        bus.i_mem_rdata <= (bus.o_mem_en === 1'b1 && bus.o_mem_wen === 1'b0) ? mem_fn(bus.o_mem_addr) : 16'h0000;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_i_req   = 1'b0;
        bus.i_i_addr  = 16'h0000;
        bus.i_d_req   = 1'b0;
        bus.i_d_wen   = 1'b0;
        bus.i_d_lock  = 1'b0;
        bus.i_d_addr  = 16'h0000;
        bus.i_d_wdata = 16'h0000;
    endtask

    task automatic push_i_read(input logic [15:0] a);
        cmd_q.push_back('{cyc + 1, 1'b0, a, 16'h0000});
        rv_q.push_back('{cyc + 2, 1'b0, mem_fn(a)});
    endtask

    task automatic push_d(input logic wen, input logic [15:0] a, input logic [15:0] wd);
        cmd_q.push_back('{cyc + 1, wen, a, wd});
        if (!wen) rv_q.push_back('{cyc + 2, 1'b1, mem_fn(a)});
    endtask

    task automatic run_monitor();
        cmd_t c;
        rv_t  r;
        logic ev_i, ev_d;
        logic [15:0] ed_i, ed_d;
        forever begin
            @(negedge i_clk);
            if (mon_en && i_rst_n === 1'b1) begin
                n_checks++;
                if (cmd_q.size() > 0 && cmd_q[0].cyc == cyc) begin
                    c = cmd_q.pop_front();
                    if (bus.o_mem_en !== 1'b1 || bus.o_mem_wen !== c.wen || bus.o_mem_addr !== c.addr ||
                        (c.wen && bus.o_mem_wdata !== c.wdata)) begin
                        n_fails++;
                        $display("FAIL mem_cmd cyc=%0d got en=%b wen=%b addr=%h wdata=%h expected en=1 wen=%b addr=%h wdata=%h",
                                 cyc, bus.o_mem_en, bus.o_mem_wen, bus.o_mem_addr, bus.o_mem_wdata, c.wen, c.addr, c.wdata);
                    end
                end else if (bus.o_mem_en !== 1'b0) begin
                    n_fails++;
                    $display("FAIL mem_idle cyc=%0d got en=%b expected en=0", cyc, bus.o_mem_en);
                end
                ev_i = 1'b0; ev_d = 1'b0; ed_i = 16'h0000; ed_d = 16'h0000;
                if (rv_q.size() > 0 && rv_q[0].cyc == cyc) begin
                    r = rv_q.pop_front();
                    if (r.port) begin ev_d = 1'b1; ed_d = r.data; end
                    else        begin ev_i = 1'b1; ed_i = r.data; end
                end
                n_checks++;
                if ({bus.o_i_rvalid, bus.o_i_rdata, bus.o_d_rvalid, bus.o_d_rdata} !== {ev_i, ed_i, ev_d, ed_d}) begin
                    n_fails++;
                    $display("FAIL rdata_route cyc=%0d got i=%b/%h d=%b/%h expected i=%b/%h d=%b/%h",
                             cyc, bus.o_i_rvalid, bus.o_i_rdata, bus.o_d_rvalid, bus.o_d_rdata, ev_i, ed_i, ev_d, ed_d);
                end
            end
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        idle_inputs();
        bus.i_i_req = 1'b1;
        bus.i_d_req = 1'b1;
        #2;
        n_checks++;
        if (bus.o_i_gnt !== 1'b0 || bus.o_d_gnt !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_gnt got i=%b d=%b expected 0 0", bus.o_i_gnt, bus.o_d_gnt);
        end
        n_checks++;
        if ({bus.o_mem_en, bus.o_mem_wen, bus.o_mem_addr, bus.o_mem_wdata} !== 34'h0) begin
            n_fails++;
            $display("FAIL reset_mem got en=%b wen=%b addr=%h wdata=%h expected all 0",
                     bus.o_mem_en, bus.o_mem_wen, bus.o_mem_addr, bus.o_mem_wdata);
        end
        n_checks++;
        if ({bus.o_i_rvalid, bus.o_i_rdata, bus.o_d_rvalid, bus.o_d_rdata} !== 34'h0) begin
            n_fails++;
            $display("FAIL reset_rvalid got i=%b/%h d=%b/%h expected all 0",
                     bus.o_i_rvalid, bus.o_i_rdata, bus.o_d_rvalid, bus.o_d_rdata);
        end
        idle_inputs();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1 mon_en = 1'b1;
    endtask

    task automatic test_i_read();
        tick();
        bus.i_i_req  = 1'b1;
        bus.i_i_addr = 16'h0010;
        #3;
        n_checks++;
        if (bus.o_i_gnt !== 1'b1 || bus.o_d_gnt !== 1'b0) begin
            n_fails++;
            $display("FAIL i_read_gnt got i=%b d=%b expected 1 0", bus.o_i_gnt, bus.o_d_gnt);
        end
        cmd_q.push_back('{cyc + 1, 1'b0, 16'h0010, 16'h0000});
        rv_q.push_back('{cyc + 2, 1'b0, 16'hBEEF});
        tick();
        idle_inputs();
        repeat (3) tick();
    endtask

    task automatic test_priority();
        for (int k = 0; k < 6; k++) begin
            tick();
            bus.i_i_req  = 1'b1;
            bus.i_i_addr = 16'h0020 + 16'(k);
            bus.i_d_req  = 1'b1;
            bus.i_d_wen  = 1'b0;
            bus.i_d_addr = 16'h0400 + 16'(k);
            #3;
            n_checks++;
            if (k == 4) begin
                if (bus.o_i_gnt !== 1'b1 || bus.o_d_gnt !== 1'b0) begin
                    n_fails++;
                    $display("FAIL prio_starved_i k=%0d got i=%b d=%b expected 1 0", k, bus.o_i_gnt, bus.o_d_gnt);
                end
                push_i_read(bus.i_i_addr);
            end else begin
                if (bus.o_i_gnt !== 1'b0 || bus.o_d_gnt !== 1'b1) begin
                    n_fails++;
                    $display("FAIL prio_d_first k=%0d got i=%b d=%b expected 0 1", k, bus.o_i_gnt, bus.o_d_gnt);
                end
                push_d(1'b0, bus.i_d_addr, 16'h0000);
            end
            if (k == 5) begin
                n_checks++;
                if (dut.r_starve_cnt !== 4'd0) begin
                    n_fails++;
                    $display("FAIL prio_starve_clr got %0d expected 0", dut.r_starve_cnt);
                end
            end
        end
        tick();
        idle_inputs();
        repeat (3) tick();
    endtask

    task automatic test_d_write();
        tick();
        bus.i_d_req   = 1'b1;
        bus.i_d_wen   = 1'b1;
        bus.i_d_addr  = 16'h0100;
        bus.i_d_wdata = 16'h1234;
        #3;
        n_checks++;
        if (bus.o_d_gnt !== 1'b1 || bus.o_i_gnt !== 1'b0) begin
            n_fails++;
            $display("FAIL d_write_gnt got i=%b d=%b expected 0 1", bus.o_i_gnt, bus.o_d_gnt);
        end
        cmd_q.push_back('{cyc + 1, 1'b1, 16'h0100, 16'h1234});
        tick();
        idle_inputs();
        repeat (3) tick();
    endtask

    task automatic test_lock();
        for (int k = 0; k < 22; k++) begin
            tick();
            bus.i_i_req  = 1'b1;
            bus.i_i_addr = 16'h0050;
            bus.i_d_req  = 1'b1;
            bus.i_d_wen  = 1'b0;
            bus.i_d_lock = (k < 20);
            bus.i_d_addr = 16'h0300 + 16'(k);
            #3;
            n_checks++;
            if (k < 21) begin
                if (bus.o_i_gnt !== 1'b0 || bus.o_d_gnt !== 1'b1) begin
                    n_fails++;
                    $display("FAIL lock_d_only k=%0d got i=%b d=%b expected 0 1", k, bus.o_i_gnt, bus.o_d_gnt);
                end
                push_d(1'b0, bus.i_d_addr, 16'h0000);
            end else begin
                if (bus.o_i_gnt !== 1'b1 || bus.o_d_gnt !== 1'b0) begin
                    n_fails++;
                    $display("FAIL lock_release_i k=%0d got i=%b d=%b expected 1 0", k, bus.o_i_gnt, bus.o_d_gnt);
                end
                push_i_read(16'h0050);
            end
            if (k == 20) begin
                n_checks++;
                if (dut.r_starve_cnt !== 4'd15) begin
                    n_fails++;
                    $display("FAIL lock_starve_sat got %0d expected 15", dut.r_starve_cnt);
                end
            end
        end
        tick();
        idle_inputs();
        repeat (3) tick();
    endtask

    task automatic test_alternating();
        for (int k = 0; k < 8; k++) begin
            tick();
            idle_inputs();
            if (k % 2 == 0) begin
                bus.i_i_req  = 1'b1;
                bus.i_i_addr = 16'h0002;
            end else begin
                bus.i_d_req  = 1'b1;
                bus.i_d_addr = 16'h0200;
            end
            #3;
            n_checks++;
            if (bus.o_i_gnt !== (k % 2 == 0) || bus.o_d_gnt !== (k % 2 == 1)) begin
                n_fails++;
                $display("FAIL alt_gnt k=%0d got i=%b d=%b expected %b %b", k, bus.o_i_gnt, bus.o_d_gnt, (k % 2 == 0), (k % 2 == 1));
            end
            if (k % 2 == 0) push_i_read(16'h0002);
            else            push_d(1'b0, 16'h0200, 16'h0000);
        end
        tick();
        idle_inputs();
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        logic sel;
        for (int k = 0; k < 30; k++) begin
            tick();
            idle_inputs();
            sel = 1'($urandom_range(0, 1));
            if (!sel) begin
                bus.i_i_req  = 1'b1;
                bus.i_i_addr = 16'($urandom);
            end else begin
                bus.i_d_req   = 1'b1;
                bus.i_d_wen   = 1'($urandom_range(0, 1));
                bus.i_d_addr  = 16'($urandom);
                bus.i_d_wdata = 16'($urandom);
            end
            #3;
            n_checks++;
            if (bus.o_i_gnt !== ~sel || bus.o_d_gnt !== sel) begin
                n_fails++;
                $display("FAIL b2b_gnt k=%0d got i=%b d=%b expected %b %b", k, bus.o_i_gnt, bus.o_d_gnt, ~sel, sel);
            end
            if (!sel) push_i_read(bus.i_i_addr);
            else      push_d(bus.i_d_wen, bus.i_d_addr, bus.i_d_wdata);
        end
        tick();
        idle_inputs();
        repeat (3) tick();
    endtask

    task automatic test_reset_inflight();
        tick();
        bus.i_i_req  = 1'b1;
        bus.i_i_addr = 16'h0040;
        #3;
        n_checks++;
        if (bus.o_i_gnt !== 1'b1) begin
            n_fails++;
            $display("FAIL rst_fly_gnt got %b expected 1", bus.o_i_gnt);
        end
        tick();
        idle_inputs();
        n_checks++;
        if (bus.o_mem_en !== 1'b1 || bus.o_mem_addr !== 16'h0040) begin
            n_fails++;
            $display("FAIL rst_fly_cmd got en=%b addr=%h expected 1 0040", bus.o_mem_en, bus.o_mem_addr);
        end
        #1 i_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.o_mem_en, bus.o_mem_wen, bus.o_mem_addr, bus.o_mem_wdata, bus.o_i_gnt, bus.o_d_gnt,
             bus.o_i_rvalid, bus.o_i_rdata, bus.o_d_rvalid, bus.o_d_rdata} !== 70'h0) begin
            n_fails++;
            $display("FAIL rst_fly_clear got en=%b addr=%h i_rv=%b d_rv=%b expected all 0",
                     bus.o_mem_en, bus.o_mem_addr, bus.o_i_rvalid, bus.o_d_rvalid);
        end
        cmd_q.delete();
        rv_q.delete();
        tick();
        n_checks++;
        if (bus.o_i_rvalid !== 1'b0 || bus.o_i_rdata !== 16'h0000) begin
            n_fails++;
            $display("FAIL rst_fly_n2 got rvalid=%b rdata=%h expected 0 0000", bus.o_i_rvalid, bus.o_i_rdata);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            #3;
            n_checks++;
            if (bus.o_i_rvalid !== 1'b0) begin
                n_fails++;
                $display("FAIL rst_fly_drop k=%0d got rvalid=%b expected 0", k, bus.o_i_rvalid);
            end
        end
    endtask

    initial begin
        i_rst_n = 1'b0;
        idle_inputs();
        fork
            run_monitor();
        join_none
        test_reset();
        test_i_read();
        test_priority();
        test_d_write();
        test_lock();
        test_alternating();
        test_back_to_back();
        test_reset_inflight();
        n_checks++;
        if (cmd_q.size() != 0 || rv_q.size() != 0) begin
            n_fails++;
            $display("FAIL scoreboard_drain got cmd=%0d rv=%0d pending expected 0 0", cmd_q.size(), rv_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
